// File: rtl/trap_timer.sv
// Memory-mapped interval timer: prescaled COUNT compared against COMPARE raises a trap
// request; the core's trap-entry store to TRAP_ADDR drops it, software clears pending.
`ifndef TRAP_ADDR
`define TRAP_ADDR 32'h0000_0100
`endif

module trap_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0200,
  parameter logic [31:0] TRAP_ADDR = `TRAP_ADDR,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic        mem_rw,
  input  logic [31:0] d_addr,
  inout  wire  [31:0] d_data,
  output logic        trap
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  logic [31:0] count_r, compare_r;
  logic [2:0]  ctrl_r;
  logic        pending_r, trap_r;
  logic [15:0] presc_r;

  logic [31:0] count_nx_s, compare_nx_s, rdata_s;
  logic [2:0]  ctrl_nx_s;
  logic        pending_nx_s, trap_nx_s;
  logic [15:0] presc_nx_s;

  logic        hit_s, wr_s, rd_s, ack_s, tick_s, match_s, count_wr_s, clr_s;
  logic [1:0]  offset_s;

  assign hit_s      = strobe && (d_addr[31:2] == BASE_ADDR[31:2]);
  assign offset_s   = d_addr[1:0];
  assign wr_s       = hit_s && mem_rw;
  // Reads are gated by reset so the bus is released while the block is held in reset.
  assign rd_s       = hit_s && !mem_rw && reset_n;
  assign ack_s      = strobe && mem_rw && (d_addr == TRAP_ADDR);
  assign count_wr_s = wr_s && (offset_s == 2'd0);
  assign clr_s      = wr_s && (offset_s == 2'd3) && d_data[0];
  assign tick_s     = ctrl_r[0] && (presc_r == PRESC_LAST);
  // A COUNT write in a tick cycle replaces the increment and suppresses the compare.
  assign match_s    = tick_s && !count_wr_s && (count_r == compare_r);

  // Register read mux for the zero-latency read path.
  always_comb begin
    rdata_s = 32'd0;
    case (offset_s)
      2'd0:    rdata_s = count_r;
      2'd1:    rdata_s = compare_r;
      2'd2:    rdata_s = {29'd0, ctrl_r};
      2'd3:    rdata_s = {30'd0, trap_r, pending_r};
      default: rdata_s = 32'd0;
    endcase
  end

  assign d_data = rd_s ? rdata_s : 32'bz;
  assign trap   = trap_r;

  // Next-state computation for prescaler, counter, registers and trap flags.
  always_comb begin
    presc_nx_s   = presc_r;
    count_nx_s   = count_r;
    compare_nx_s = compare_r;
    ctrl_nx_s    = ctrl_r;
    pending_nx_s = pending_r;
    trap_nx_s    = trap_r;

    if (count_wr_s) begin
      presc_nx_s = 16'd0;
    end else if (ctrl_r[0]) begin
      presc_nx_s = tick_s ? 16'd0 : presc_r + 16'd1;
    end else begin
      presc_nx_s = presc_r;
    end

    if (count_wr_s) begin
      count_nx_s = d_data;
    end else if (tick_s) begin
      count_nx_s = (match_s && ctrl_r[1]) ? 32'd0 : count_r + 32'd1;
    end else begin
      count_nx_s = count_r;
    end

    if (wr_s && (offset_s == 2'd1)) begin
      compare_nx_s = d_data;
    end else begin
      compare_nx_s = compare_r;
    end

    if (wr_s && (offset_s == 2'd2)) begin
      ctrl_nx_s = d_data[2:0];
    end else begin
      ctrl_nx_s = ctrl_r;
    end

    if (match_s) begin
      pending_nx_s = 1'b1;
    end else if (clr_s) begin
      pending_nx_s = 1'b0;
    end else begin
      pending_nx_s = pending_r;
    end

    // Set beats clear: a match with TRAP_EN wins over both STATUS clear and ack.
    if (match_s && ctrl_r[2]) begin
      trap_nx_s = 1'b1;
    end else if (clr_s || ack_s) begin
      trap_nx_s = 1'b0;
    end else begin
      trap_nx_s = trap_r;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_r   <= 16'd0;
      count_r   <= 32'd0;
      compare_r <= 32'hFFFF_FFFF;
      ctrl_r    <= 3'd0;
      pending_r <= 1'b0;
      trap_r    <= 1'b0;
    end else begin
      presc_r   <= presc_nx_s;
      count_r   <= count_nx_s;
      compare_r <= compare_nx_s;
      ctrl_r    <= ctrl_nx_s;
      pending_r <= pending_nx_s;
      trap_r    <= trap_nx_s;
    end
  end

endmodule

// File: tb/tb_trap_timer.sv
// Directed bench for trap_timer: two instances (PRESCALE 1 and 4) share one pulled-up bus;
// read results flow through an expected-value queue.
module tb_trap_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        strobe = 1'b0;
  logic        mem_rw = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] drv = 32'd0;
  logic        oe = 1'b0;
  logic        trap1, trap4;
  wire  [31:0] d_data;

  assign d_data = oe ? drv : 32'bz;
  pullup (d_data);

  always #5 clk = ~clk;

  trap_timer #(.BASE_ADDR(32'h0000_0200), .TRAP_ADDR(32'h0000_0100), .PRESCALE(1)) u_t1 (
    .clk(clk), .reset_n(reset_n), .strobe(strobe), .mem_rw(mem_rw),
    .d_addr(d_addr), .d_data(d_data), .trap(trap1));

  trap_timer #(.BASE_ADDR(32'h0000_0300), .TRAP_ADDR(32'h0000_0104), .PRESCALE(4)) u_t4 (
    .clk(clk), .reset_n(reset_n), .strobe(strobe), .mem_rw(mem_rw),
    .d_addr(d_addr), .d_data(d_data), .trap(trap4));

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    @(negedge clk);
    strobe = 1'b1; mem_rw = 1'b0; d_addr = addr; oe = 1'b0;
    exp_q.push_back(exp);
    #2;
    e = exp_q.pop_front();
    check(tag, d_data, e);
    @(posedge clk); #1;
    strobe = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    strobe = 1'b1; mem_rw = 1'b1; d_addr = addr; drv = data; oe = 1'b1;
    @(posedge clk); #1;
    strobe = 1'b0; mem_rw = 1'b0; oe = 1'b0;
  endtask

  initial begin
    // Reset state and idle bus
    #3;
    check("rst_trap1", {31'd0, trap1}, 32'd0);
    check("rst_trap4", {31'd0, trap4}, 32'd0);
    check("rst_bus_idle", d_data, 32'hFFFF_FFFF);
    @(negedge clk); #2 reset_n = 1'b1;
    rd(32'h201, 32'hFFFF_FFFF, "rst_compare");
    rd(32'h200, 32'h0, "rst_count");
    rd(32'h303, 32'h0, "rst_status4");
    rd(32'h204, 32'hFFFF_FFFF, "nonhit_bus_z");

    // RELOAD sequence with PRESCALE=1, plus STATUS clear colliding with a match
    wr(32'h201, 32'd2);
    wr(32'h202, 32'b011);
    rd(32'h200, 32'd0, "reload_c0");
    rd(32'h200, 32'd1, "reload_c1");
    rd(32'h200, 32'd2, "reload_c2");
    rd(32'h200, 32'd0, "reload_c0b");
    rd(32'h203, 32'h1, "reload_pending");
    wr(32'h203, 32'h1);
    rd(32'h203, 32'h1, "clr_vs_match");
    wr(32'h203, 32'h1);
    rd(32'h203, 32'h0, "clr_status");
    rd(32'h200, 32'd0, "reload_c0c");
    rd(32'h203, 32'h1, "reload_pending2");

    // COUNT write during a matching tick
    wr(32'h202, 32'd0);
    wr(32'h203, 32'h1);
    wr(32'h200, 32'd0);
    wr(32'h202, 32'b001);
    rd(32'h200, 32'd0, "cw_c0");
    rd(32'h200, 32'd1, "cw_c1");
    wr(32'h200, 32'd9);
    rd(32'h200, 32'd9, "cw_value");
    rd(32'h203, 32'h0, "cw_no_match");

    // PRESCALE=4: trap on the 16th enabled clock
    wr(32'h301, 32'd3);
    wr(32'h302, 32'b101);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("presc_trap_early", {31'd0, trap4}, 32'd0);
    @(negedge clk);
    check("presc_trap_set", {31'd0, trap4}, 32'd1);
    rd(32'h303, 32'h3, "presc_status");
    wr(32'h300, 32'd100);
    rd(32'h300, 32'd100, "presc_clr_0");
    rd(32'h300, 32'd100, "presc_clr_1");
    rd(32'h300, 32'd100, "presc_clr_2");
    rd(32'h300, 32'd100, "presc_clr_3");
    rd(32'h300, 32'd101, "presc_clr_tick");

    // Trap acknowledge via store to TRAP_ADDR
    wr(32'h104, 32'h1234_5678);
    @(negedge clk);
    check("ack_trap_low", {31'd0, trap4}, 32'd0);
    rd(32'h303, 32'h1, "ack_pending_kept");
    wr(32'h303, 32'h1);
    rd(32'h303, 32'h0, "ack_status_clr");
    wr(32'h302, 32'd0);

    // 32-bit wrap, no event until COUNT reaches COMPARE
    wr(32'h202, 32'd0);
    wr(32'h201, 32'd5);
    wr(32'h200, 32'hFFFF_FFFE);
    wr(32'h203, 32'h1);
    wr(32'h202, 32'b101);
    rd(32'h200, 32'hFFFF_FFFE, "wrap_fffe");
    rd(32'h200, 32'hFFFF_FFFF, "wrap_ffff");
    rd(32'h200, 32'd0, "wrap_0");
    rd(32'h200, 32'd1, "wrap_1");
    rd(32'h200, 32'd2, "wrap_2");
    rd(32'h200, 32'd3, "wrap_3");
    rd(32'h200, 32'd4, "wrap_4");
    rd(32'h203, 32'h0, "wrap_no_event");
    rd(32'h203, 32'h3, "wrap_event");
    check("wrap_trap", {31'd0, trap1}, 32'd1);

    // Asynchronous reset in the middle of a read access while counting
    @(negedge clk);
    strobe = 1'b1; mem_rw = 1'b0; d_addr = 32'h200;
    #1 reset_n = 1'b0;
    #1;
    check("midrst_bus_z", d_data, 32'hFFFF_FFFF);
    check("midrst_trap1", {31'd0, trap1}, 32'd0);
    strobe = 1'b0;
    @(negedge clk); #2 reset_n = 1'b1;
    rd(32'h201, 32'hFFFF_FFFF, "midrst_compare");
    rd(32'h200, 32'd0, "midrst_count");
    rd(32'h202, 32'd0, "midrst_ctrl");
    rd(32'h203, 32'd0, "midrst_status");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
